// File: rtl/slide_scan.sv
// rtl/slide_scan.sv - round-robin ADC scan sequencer with per-slot exponential smoothing
module slide_scan #(
  parameter int NUM_CH    = 6,
  parameter int RES_W     = 12,
  parameter int CHNL_W    = 3,
  parameter logic [NUM_CH*CHNL_W-1:0] CH_MAP = {3'd7, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
  parameter int AVG_SHIFT = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       err_clr,
  input  logic                       cnv_cmplt,
  input  logic [RES_W-1:0]           res,
  output logic [CHNL_W-1:0]          chnnl,
  output logic                       strt_cnv,
  output logic [NUM_CH*RES_W-1:0]    pot_out,
  output logic                       upd_vld,
  output logic [$clog2(NUM_CH)-1:0]  upd_idx,
  output logic                       scan_done,
  output logic                       timeout_err
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int AW    = RES_W + AVG_SHIFT;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [TW-1:0]    T_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, UPDATE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic              wrap;
  logic [TW-1:0]     timer;
  logic [RES_W-1:0]  res_q;
  logic [AW-1:0]     acc [NUM_CH];
  logic [NUM_CH-1:0] primed;
  logic [AW-1:0]     acc_cur;
  logic [AW-1:0]     acc_new;

  assign wrap     = (idx == LAST_IDX);
  assign idx_nxt  = wrap ? '0 : idx + 1'b1;
  assign strt_cnv = (state == START);

  // The first sample seeds the accumulator so the slot starts at the real value, not ramping from 0.
  always_comb begin
    acc_cur = acc[idx];
    acc_new = AW'(res_q) << AVG_SHIFT;
    if (primed[idx]) begin
      acc_new = acc_cur - (acc_cur >> AVG_SHIFT) + AW'(res_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      chnnl       <= CH_MAP[CHNL_W-1:0];
      timer       <= '0;
      res_q       <= '0;
      pot_out     <= '0;
      upd_vld     <= 1'b0;
      upd_idx     <= '0;
      scan_done   <= 1'b0;
      timeout_err <= 1'b0;
      primed      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
      end
    end else begin
      upd_vld   <= 1'b0;
      scan_done <= 1'b0;
      if (err_clr) begin
        timeout_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (en) begin
            state <= START;
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Completion takes priority over a timeout landing on the same edge.
          if (cnv_cmplt) begin
            res_q <= res;
            state <= UPDATE;
          end else if (timer == T_LAST) begin
            timeout_err <= 1'b1;
            idx         <= idx_nxt;
            chnnl       <= CH_MAP[idx_nxt*CHNL_W +: CHNL_W];
            scan_done   <= wrap;
            state       <= en ? START : IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        UPDATE: begin
          acc[idx]                     <= acc_new;
          primed[idx]                  <= 1'b1;
          pot_out[idx*RES_W +: RES_W]  <= RES_W'(acc_new >> AVG_SHIFT);
          upd_vld                      <= 1'b1;
          upd_idx                      <= idx;
          idx                          <= idx_nxt;
          chnnl                        <= CH_MAP[idx_nxt*CHNL_W +: CHNL_W];
          scan_done                    <= wrap;
          state                        <= en ? START : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slide_scan.sv
// tb/tb_slide_scan.sv - directed-vector bench for slide_scan with a behavioural ADC
module tb_slide_scan;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        err_clr;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic [2:0]  chnnl;
  logic        strt_cnv;
  logic [71:0] pot_out;
  logic        upd_vld;
  logic [2:0]  upd_idx;
  logic        scan_done;
  logic        timeout_err;

  int n_vec = 0;
  int n_bad = 0;

  logic [11:0] val_tab [8];
  int          lat_tab [8];
  bit          mute_tab [8];

  slide_scan #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .err_clr(err_clr),
    .cnv_cmplt(cnv_cmplt), .res(res), .chnnl(chnnl), .strt_cnv(strt_cnv),
    .pot_out(pot_out), .upd_vld(upd_vld), .upd_idx(upd_idx),
    .scan_done(scan_done), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // ADC model: answers lat_tab[ch] negedges after the strt_cnv pulse unless muted.
  initial begin
    bit          pending;
    int          cnt;
    logic [11:0] rv;
    pending   = 0;
    cnt       = 0;
    rv        = '0;
    cnv_cmplt = 1'b0;
    res       = '0;
    forever begin
      @(negedge clk);
      cnv_cmplt = 1'b0;
      if (!rst_n) begin
        pending = 0;
      end else begin
        if (pending) begin
          if (cnt <= 1) begin
            cnv_cmplt = 1'b1;
            res       = rv;
            pending   = 0;
          end else begin
            cnt--;
          end
        end
        if (strt_cnv && !mute_tab[chnnl]) begin
          pending = 1;
          cnt     = lat_tab[chnnl];
          rv      = val_tab[chnnl];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] slot(input int i);
    return pot_out[i*12 +: 12];
  endfunction

  task automatic set_tables();
    for (int i = 0; i < 8; i++) begin
      val_tab[i]  = 12'(16'h100 * (i + 1));
      lat_tab[i]  = 5;
      mute_tab[i] = 0;
    end
    val_tab[7] = 12'h600;
  endtask

  task automatic do_reset();
    set_tables();
    en      = 1'b0;
    err_clr = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
  endtask

  task automatic wait_upd(input int s, output logic [11:0] v);
    bit ok = 0;
    v = 12'hfff;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (upd_vld && upd_idx == 3'(s)) begin
        ok = 1;
        v  = slot(s);
      end
    end
    check("wait_upd", 96'(ok), 96'd1);
  endtask

  task automatic wait_strt(input int ch, input bit any_ch, output logic [2:0] got_ch);
    bit ok = 0;
    got_ch = 3'bx;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (strt_cnv && (any_ch || chnnl == 3'(ch))) begin
        ok     = 1;
        got_ch = chnnl;
      end
    end
    check("wait_strt", 96'(ok), 96'd1);
  endtask

  initial begin
    logic [11:0] v;
    logic [2:0]  ch;
    int          exp_ch [6] = '{0, 1, 2, 3, 4, 7};
    int          s_ch [6];
    int          u_idx [6];
    int          u_val [6];
    int          n_s;
    int          n_u;
    int          k;
    int          n_strt;
    bit          got;
    bit          hit;
    bit          saw_upd;

    set_tables();
    rst_n   = 1'b0;
    en      = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_chnnl", 96'(chnnl), 96'd0);
    check("rst_strt", 96'(strt_cnv), 96'd0);
    check("rst_pot", 96'(pot_out), 96'd0);
    check("rst_upd", 96'({upd_vld, upd_idx}), 96'd0);
    check("rst_done", 96'(scan_done), 96'd0);
    check("rst_err", 96'(timeout_err), 96'd0);
    rst_n = 1'b1;

    // first full pass: channel order, slot order, primed seed values, single scan_done
    en  = 1'b1;
    n_s = 0;
    n_u = 0;
    got = 0;
    for (int i = 0; i < 6; i++) begin
      s_ch[i] = -1; u_idx[i] = -1; u_val[i] = -1;
    end
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (strt_cnv && n_s < 6) begin
        s_ch[n_s] = int'(chnnl);
        n_s++;
      end
      if (upd_vld && n_u < 6) begin
        u_idx[n_u] = int'(upd_idx);
        u_val[n_u] = int'(slot(int'(upd_idx)));
        n_u++;
      end
      if (scan_done) begin
        got = 1;
        check("done_with_slot5", 96'({upd_vld, upd_idx}), 96'({1'b1, 3'd5}));
        check("done_upd_count", 96'(n_u), 96'd6);
      end
    end
    check("pass1_done", 96'(got), 96'd1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("pass1_ch%0d", i), 96'(s_ch[i]), 96'(exp_ch[i]));
      check($sformatf("pass1_idx%0d", i), 96'(u_idx[i]), 96'(i));
      check($sformatf("pass1_val%0d", i), 96'(u_val[i]), 96'(256 * (i + 1)));
    end

    // smoothing with S=2 on slot 0
    do_reset();
    val_tab[0] = 12'h000;
    en = 1'b1;
    wait_upd(0, v);
    check("avg_seed", 96'(v), 96'h000);
    val_tab[0] = 12'h400;
    wait_upd(0, v);
    check("avg_1", 96'(v), 96'h100);
    wait_upd(0, v);
    check("avg_2", 96'(v), 96'h1c0);
    wait_upd(0, v);
    check("avg_3", 96'(v), 96'h250);

    // conversion timeout on channel 2
    do_reset();
    mute_tab[2] = 1;
    en = 1'b1;
    wait_strt(2, 0, ch);
    k = 0;
    hit = 0;
    saw_upd = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      k++;
      if (upd_vld) saw_upd = 1;
      if (timeout_err) hit = 1;
    end
    check("to_cycles", 96'(k), 96'd17);
    check("to_no_upd", 96'(saw_upd), 96'd0);
    check("to_next_strt", 96'({strt_cnv, chnnl}), 96'({1'b1, 3'd3}));
    check("to_slot2", 96'(slot(2)), 96'd0);
    check("to_slot1", 96'(slot(1)), 96'h200);
    mute_tab[2] = 0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("to_err_clr", 96'(timeout_err), 96'd0);

    // completion on the last timer cycle wins
    do_reset();
    lat_tab[2] = 16;
    en = 1'b1;
    wait_upd(2, v);
    check("exact_val", 96'(v), 96'h300);
    check("exact_err", 96'(timeout_err), 96'd0);

    // en dropped during WAIT on idx 3
    do_reset();
    en = 1'b1;
    wait_strt(3, 0, ch);
    @(negedge clk);
    en = 1'b0;
    wait_upd(3, v);
    check("en_drop_val", 96'(v), 96'h400);
    n_strt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (strt_cnv) n_strt++;
    end
    check("en_drop_idle", 96'(n_strt), 96'd0);
    en = 1'b1;
    wait_strt(0, 1, ch);
    check("en_resume_ch", 96'(ch), 96'd4);

    // reset mid-WAIT clears everything, including primed flags
    do_reset();
    en = 1'b1;
    wait_upd(0, v);
    check("rr_pre", 96'(v), 96'h100);
    val_tab[0] = 12'h500;
    wait_strt(1, 0, ch);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rr_chnnl", 96'(chnnl), 96'd0);
    check("rr_pot", 96'(pot_out), 96'd0);
    check("rr_outs", 96'({strt_cnv, upd_vld, upd_idx, scan_done, timeout_err}), 96'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_upd(0, v);
    check("rr_reseed", 96'(v), 96'h500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
